// File: rtl/glitch_pkg.sv
// Shared types and constants for the clock-glitch sweep sequencer.
package glitch_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRstCard,
        StArm,
        StGlitch,
        StCool,
        StAdvance,
        StDone
    } state_e;

    localparam logic [2:0] CFG_CLK_START = 3'd0;
    localparam logic [2:0] CFG_CLK_STOP  = 3'd1;
    localparam logic [2:0] CFG_CLK_STEP  = 3'd2;
    localparam logic [2:0] CFG_IO_TARGET = 3'd3;
    localparam logic [2:0] CFG_PULSE_W   = 3'd4;
    localparam logic [2:0] CFG_REPEATS   = 3'd5;
    localparam logic [2:0] CFG_TIMEOUT   = 3'd6;
    localparam logic [2:0] CFG_COOLDOWN  = 3'd7;

    // Cycles the card is held in reset at the start of every attempt.
    localparam int unsigned RST_HOLD = 16;

endpackage

// File: rtl/glitch_pulse_gen.sv
// Glitch pulse generator: drives the glitch for max(pulse_w,1) cycles after a fire.
module glitch_pulse_gen #(
    parameter int unsigned PW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clear,
    input  logic          i_fire,
    input  logic [PW-1:0] i_pulse_w,
    output logic          o_glitch,
    output logic          o_pulse_done
);

    logic [PW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_fire) begin
            r_cnt <= (i_pulse_w == '0) ? PW'(1) : i_pulse_w;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - PW'(1);
        end
    end

    assign o_glitch     = (r_cnt != '0);
    // Asserted during the final glitch cycle so the sequencer leaves in step with the pulse.
    assign o_pulse_done = (r_cnt == PW'(1));

endmodule

// File: rtl/glitch_sweep_sequencer.sv
// Clock-glitch sweep sequencer: reset card, arm, glitch on trigger, cool down, advance offset.
module glitch_sweep_sequencer
    import glitch_pkg::*;
#(
    parameter int unsigned CW = 32,
    parameter int unsigned PW = 8,
    parameter int unsigned RW = 8
) (
    input  logic          i_sc_clk,
    input  logic          i_sc_reset,
    input  logic          i_cfg_we,
    input  logic [2:0]    i_cfg_addr,
    input  logic [CW-1:0] i_cfg_wdata,
    input  logic          i_start,
    input  logic          i_abort,
    input  logic          i_trig_fired,
    output logic          o_card_rst_n,
    output logic [CW-1:0] o_io_edge_target,
    output logic [CW-1:0] o_clk_edge_target,
    output logic          o_glitch,
    output logic          o_busy,
    output logic          o_done,
    output logic [15:0]   o_miss_count
);

    state_e        r_state, w_state_d;
    logic [CW-1:0] r_clk_start, r_clk_stop, r_clk_step, r_io_target, r_timeout, r_cooldown;
    logic [PW-1:0] r_pulse_w;
    logic [RW-1:0] r_repeats, r_rep;
    logic [CW-1:0] r_cnt, r_offset;
    logic          r_trig_q, r_done;
    logic [15:0]   r_miss;

    logic          w_trig_edge, w_timeout, w_cool_last, w_pulse_done;
    logic          w_rep_more, w_sweep_end, w_go, w_cfg_wr, w_fire, w_miss_inc;
    logic [RW:0]   w_rep_inc;
    logic [RW-1:0] w_rep_lim;
    logic [CW:0]   w_next;

    assign w_trig_edge = i_trig_fired && !r_trig_q;
    assign w_timeout   = (r_timeout != '0) && (r_cnt == r_timeout - CW'(1));
    assign w_cool_last = (r_cooldown == '0) || (r_cnt == r_cooldown - CW'(1));
    assign w_rep_inc   = {1'b0, r_rep} + (RW + 1)'(1);
    assign w_rep_lim   = (r_repeats == '0) ? RW'(1) : r_repeats;
    assign w_rep_more  = (w_rep_inc < {1'b0, w_rep_lim});
    // One extra bit so a wrap past the top of the offset range ends the sweep.
    assign w_next      = {1'b0, r_offset} + {1'b0, r_clk_step};
    assign w_sweep_end = (r_clk_step == '0) || (w_next > {1'b0, r_clk_stop});
    assign w_go        = (r_state == StIdle) && i_start && !i_abort;
    assign w_cfg_wr    = (r_state == StIdle) && i_cfg_we;
    assign w_fire      = (r_state == StArm) && w_trig_edge && !i_abort;
    assign w_miss_inc  = (r_state == StArm) && !w_trig_edge && w_timeout && !i_abort;

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:    if (i_start) w_state_d = StRstCard;
            StRstCard: if (r_cnt == CW'(RST_HOLD - 1)) w_state_d = StArm;
            StArm: begin
                if (w_trig_edge)    w_state_d = StGlitch;
                else if (w_timeout) w_state_d = StCool;
            end
            StGlitch:  if (w_pulse_done) w_state_d = StCool;
            StCool:    if (w_cool_last) w_state_d = StAdvance;
            StAdvance: w_state_d = (!w_rep_more && w_sweep_end) ? StDone : StRstCard;
            StDone:    w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
        if (i_abort) w_state_d = StIdle;
    end

    always_ff @(posedge i_sc_clk or posedge i_sc_reset) begin
        if (i_sc_reset) r_state <= StIdle;
        else            r_state <= w_state_d;
    end

    always_ff @(posedge i_sc_clk or posedge i_sc_reset) begin
        if (i_sc_reset) begin
            r_clk_start <= '0;
            r_clk_stop  <= '0;
            r_clk_step  <= '0;
            r_io_target <= '0;
            r_pulse_w   <= '0;
            r_repeats   <= '0;
            r_timeout   <= '0;
            r_cooldown  <= '0;
            r_cnt       <= '0;
            r_offset    <= '0;
            r_rep       <= '0;
            r_trig_q    <= 1'b0;
            r_done      <= 1'b0;
            r_miss      <= '0;
        end else begin
            r_trig_q <= i_trig_fired;
            // Per-state cycle counter restarts on every state change.
            r_cnt    <= ((w_state_d != r_state) || (r_state == StIdle)) ? '0 : r_cnt + CW'(1);
            if (w_cfg_wr) begin
                case (i_cfg_addr)
                    CFG_CLK_START: r_clk_start <= i_cfg_wdata;
                    CFG_CLK_STOP:  r_clk_stop  <= i_cfg_wdata;
                    CFG_CLK_STEP:  r_clk_step  <= i_cfg_wdata;
                    CFG_IO_TARGET: r_io_target <= i_cfg_wdata;
                    CFG_PULSE_W:   r_pulse_w   <= i_cfg_wdata[PW-1:0];
                    CFG_REPEATS:   r_repeats   <= i_cfg_wdata[RW-1:0];
                    CFG_TIMEOUT:   r_timeout   <= i_cfg_wdata;
                    CFG_COOLDOWN:  r_cooldown  <= i_cfg_wdata;
                endcase
            end
            if (w_go) begin
                r_offset <= r_clk_start;
                r_rep    <= '0;
                r_done   <= 1'b0;
                r_miss   <= '0;
            end
            if (w_miss_inc && (r_miss != 16'hFFFF)) r_miss <= r_miss + 16'd1;
            if ((r_state == StAdvance) && !i_abort) begin
                if (w_rep_more) begin
                    r_rep <= w_rep_inc[RW-1:0];
                end else begin
                    r_rep <= '0;
                    if (!w_sweep_end) r_offset <= w_next[CW-1:0];
                end
            end
            if (w_state_d == StDone) r_done <= 1'b1;
        end
    end

    glitch_pulse_gen #(
        .PW (PW)
    ) u_pulse_gen (
        .i_clk        (i_sc_clk),
        .i_rst        (i_sc_reset),
        .i_clear      (i_abort),
        .i_fire       (w_fire),
        .i_pulse_w    (r_pulse_w),
        .o_glitch     (o_glitch),
        .o_pulse_done (w_pulse_done)
    );

    assign o_card_rst_n      = (r_state != StRstCard);
    assign o_busy            = (r_state != StIdle);
    assign o_done            = r_done;
    assign o_miss_count      = r_miss;
    assign o_io_edge_target  = r_io_target;
    assign o_clk_edge_target = (r_state == StIdle) ? r_clk_start : r_offset;

endmodule

// File: tb/tb_glitch_sweep_sequencer.sv
// Self-checking bench: exact-timing corner sequences, a sweep table and random sweeps vs a model.
module tb_glitch_sweep_sequencer;
    import glitch_pkg::*;

    logic        sc_clk = 1'b0;
    logic        sc_reset = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_addr = 3'd0;
    logic [31:0] cfg_wdata = '0;
    logic        start = 1'b0, abort = 1'b0, trig = 1'b0;
    logic        card_rst_n, glitch, busy, done;
    logic [31:0] io_tgt, clk_tgt;
    logic [15:0] miss_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_offs[$];
    logic [31:0] got_offs[$];

    typedef struct packed {
        logic [31:0] st, sp, stp;
        logic [7:0]  pw, reps;
        logic [31:0] tmo, cool;
        int          dly;
        int          e_att, e_gl, e_miss;
    } vec_t;

    vec_t tbl [9];

    glitch_sweep_sequencer #(.CW(32), .PW(8), .RW(8)) dut (
        .i_sc_clk          (sc_clk),
        .i_sc_reset        (sc_reset),
        .i_cfg_we          (cfg_we),
        .i_cfg_addr        (cfg_addr),
        .i_cfg_wdata       (cfg_wdata),
        .i_start           (start),
        .i_abort           (abort),
        .i_trig_fired      (trig),
        .o_card_rst_n      (card_rst_n),
        .o_io_edge_target  (io_tgt),
        .o_clk_edge_target (clk_tgt),
        .o_glitch          (glitch),
        .o_busy            (busy),
        .o_done            (done),
        .o_miss_count      (miss_count)
    );

    always #5 sc_clk = ~sc_clk;

    task automatic tick();
        @(posedge sc_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic configure(input vec_t v, input logic [31:0] io);
        cfg_write(CFG_CLK_START, v.st);
        cfg_write(CFG_CLK_STOP, v.sp);
        cfg_write(CFG_CLK_STEP, v.stp);
        cfg_write(CFG_IO_TARGET, io);
        cfg_write(CFG_PULSE_W, {24'd0, v.pw});
        cfg_write(CFG_REPEATS, {24'd0, v.reps});
        cfg_write(CFG_TIMEOUT, v.tmo);
        cfg_write(CFG_COOLDOWN, v.cool);
    endtask

    // Reference: every attempt's offset, each offset repeated max(reps,1) times.
    function automatic void model(input logic [31:0] st, sp, stp, input logic [7:0] reps);
        logic [32:0] nx;
        logic [31:0] off;
        int          r;
        exp_offs.delete();
        off = st;
        r   = (reps == 0) ? 1 : int'(reps);
        for (int g = 0; g < 1000; g++) begin
            for (int i = 0; i < r; i++) exp_offs.push_back(off);
            nx = {1'b0, off} + {1'b0, stp};
            if (stp == 0 || nx > {1'b0, sp}) break;
            off = nx[31:0];
        end
    endfunction

    task automatic wait_arm(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (card_rst_n) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    // Starts a sweep and plays the trigger: pulse at ARM cycle dly (dly<0: never).
    task automatic run_sweep(input int dly, input int exp_w, output int n_att, output int n_gl,
                             output int n_bad_w, output logic dn, output logic [15:0] miss,
                             output bit tmo_hit);
        int   c, w;
        logic prev_rst;
        got_offs.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        n_att = 0; n_gl = 0; n_bad_w = 0; w = 0; c = 1000000;
        prev_rst = card_rst_n;
        tmo_hit = 1'b1;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (!busy) begin tmo_hit = 1'b0; break; end
            if (card_rst_n && !prev_rst) begin
                n_att++;
                got_offs.push_back(clk_tgt);
                c = 0;
            end
            trig = (dly >= 0) && (c == dly);
            c++;
            if (glitch) w++;
            else if (w > 0) begin
                n_gl++;
                if (w != exp_w) n_bad_w++;
                w = 0;
            end
            prev_rst = card_rst_n;
            tick();
        end
        trig = 1'b0;
        dn   = done;
        miss = miss_count;
    endtask

    function automatic int offs_mismatch();
        int bad = 0;
        if (got_offs.size() != exp_offs.size()) return 1000 + got_offs.size();
        foreach (exp_offs[i]) if (got_offs[i] !== exp_offs[i]) bad++;
        return bad;
    endfunction

    task automatic sweep_and_check(input string tag, input vec_t v, input int e_att,
                                   input int e_gl, input int e_miss);
        int         att, gl, badw;
        logic       dn;
        logic [15:0] ms;
        bit         to;
        configure(v, 32'h0);
        model(v.st, v.sp, v.stp, v.reps);
        run_sweep(v.dly, (v.pw == 0) ? 1 : int'(v.pw), att, gl, badw, dn, ms, to);
        check({tag, " no timeout"}, 64'(to), 64'd0);
        check({tag, " attempts"}, 64'(att), 64'(e_att));
        check({tag, " glitches"}, 64'(gl), 64'(e_gl));
        check({tag, " glitch width errors"}, 64'(badw), 64'd0);
        check({tag, " miss_count"}, 64'(ms), 64'(e_miss));
        check({tag, " done"}, 64'(dn), 64'd1);
        check({tag, " offset errors"}, 64'(offs_mismatch()), 64'd0);
    endtask

    initial begin
        bit   ok;
        int   gl_seen;
        vec_t v;
        int   att, gl, badw;
        logic dn;
        logic [15:0] ms;
        bit   to;

        tbl[0] = '{32'd100, 32'd110, 32'd5, 8'd3, 8'd1, 32'd0, 32'd2, 2, 3, 3, 0};
        tbl[1] = '{32'd50, 32'd50, 32'd7, 8'd1, 8'd2, 32'd0, 32'd0, 0, 2, 2, 0};
        tbl[2] = '{32'd10, 32'd13, 32'd1, 8'd2, 8'd1, 32'd20, 32'd1, -1, 4, 0, 4};
        tbl[3] = '{32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 8'd2, 8'd1, 32'd0, 32'd0, 1, 1, 1, 0};
        tbl[4] = '{32'd200, 32'd100, 32'd1, 8'd4, 8'd1, 32'd0, 32'd3, 3, 1, 1, 0};
        tbl[5] = '{32'd5, 32'd100, 32'd0, 8'd1, 8'd1, 32'd0, 32'd0, 0, 1, 1, 0};
        tbl[6] = '{32'd0, 32'd2, 32'd1, 8'd0, 8'd0, 32'd0, 32'd1, 1, 3, 3, 0};
        tbl[7] = '{32'd7, 32'd7, 32'd1, 8'd2, 8'd1, 32'd4, 32'd0, 3, 1, 1, 0};
        tbl[8] = '{32'd7, 32'd7, 32'd1, 8'd2, 8'd1, 32'd3, 32'd0, 3, 1, 0, 1};

        tick(); tick();
        sc_reset = 1'b0;
        tick();
        check("reset card_rst_n", 64'(card_rst_n), 64'd1);
        check("reset glitch", 64'(glitch), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset miss_count", 64'(miss_count), 64'd0);
        check("reset io target", 64'(io_tgt), 64'd0);
        check("reset clk target", 64'(clk_tgt), 64'd0);

        // Config write latency, start timing, reset hold, pre-high trigger, PULSE_W=0.
        cfg_we = 1'b1; cfg_addr = CFG_IO_TARGET; cfg_wdata = 32'hABCD;
        check("io target before write edge", 64'(io_tgt), 64'd0);
        tick();
        cfg_we = 1'b0;
        check("io target after write", 64'(io_tgt), 64'hABCD);
        v = '{32'd300, 32'd300, 32'd1, 8'd0, 8'd1, 32'd0, 32'd0, 0, 0, 0, 0};
        configure(v, 32'hABCD);
        check("idle clk target is CLK_START", 64'(clk_tgt), 64'd300);
        trig  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy after start", 64'(busy), 64'd1);
        check("card_rst_n after start", 64'(card_rst_n), 64'd0);
        cfg_we = 1'b1; cfg_addr = CFG_IO_TARGET; cfg_wdata = 32'h5555;
        for (int i = 2; i <= 16; i++) begin
            tick();
            cfg_we = 1'b0;
        end
        check("card_rst_n held at cycle 16", 64'(card_rst_n), 64'd0);
        tick();
        check("card_rst_n released at cycle 17", 64'(card_rst_n), 64'd1);
        check("config write ignored while busy", 64'(io_tgt), 64'hABCD);
        gl_seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (glitch) gl_seen++;
        end
        check("held-high trigger is not an edge", 64'(gl_seen), 64'd0);
        trig = 1'b0;
        tick();
        trig = 1'b1;
        tick();
        check("glitch at k+1 (PULSE_W=0)", 64'(glitch), 64'd1);
        trig = 1'b0;
        tick();
        check("glitch low at k+2 (PULSE_W=0)", 64'(glitch), 64'd0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) begin ok = 1'b1; break; end
            tick();
        end
        check("sweep ends after edge", 64'(ok), 64'd1);
        check("done after single-offset sweep", 64'(done), 64'd1);

        for (int i = 0; i < 9; i++) begin
            sweep_and_check($sformatf("tbl%0d", i), tbl[i], tbl[i].e_att, tbl[i].e_gl,
                            tbl[i].e_miss);
        end
        tick(); tick();
        check("done sticky while idle", 64'(done), 64'd1);

        // Abort in the middle of a glitch pulse, then restart.
        v = '{32'd400, 32'd400, 32'd1, 8'd5, 8'd1, 32'd0, 32'd0, 0, 0, 0, 0};
        configure(v, 32'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_arm(ok);
        check("abort test reached ARM", 64'(ok), 64'd1);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("abort test glitch cycle 1", 64'(glitch), 64'd1);
        tick();
        check("abort test glitch cycle 2", 64'(glitch), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("glitch low after abort", 64'(glitch), 64'd0);
        check("busy low after abort", 64'(busy), 64'd0);
        check("done low after abort", 64'(done), 64'd0);
        check("card_rst_n high after abort", 64'(card_rst_n), 64'd1);
        model(v.st, v.sp, v.stp, v.reps);
        run_sweep(0, 5, att, gl, badw, dn, ms, to);
        check("restart no timeout", 64'(to), 64'd0);
        check("restart attempts", 64'(att), 64'd1);
        check("restart glitch width errors", 64'(badw), 64'd0);
        check("restart done", 64'(dn), 64'd1);

        for (int r = 0; r < 20; r++) begin
            v.st   = (r % 5 == 4) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : 32'($urandom);
            v.sp   = (r % 7 == 6) ? v.st - 32'd3 : v.st + 32'($urandom_range(0, 12));
            v.stp  = 32'($urandom_range(0, 5));
            v.pw   = 8'($urandom_range(0, 5));
            v.reps = 8'($urandom_range(0, 2));
            v.cool = 32'($urandom_range(0, 4));
            if ($urandom_range(0, 1) == 0) begin
                v.dly = -1;
                v.tmo = 32'($urandom_range(1, 8));
            end else begin
                v.dly = int'($urandom_range(0, 5));
                v.tmo = ($urandom_range(0, 1) == 0) ? 32'd0
                                                    : 32'($urandom_range(v.dly + 1, v.dly + 6));
            end
            model(v.st, v.sp, v.stp, v.reps);
            sweep_and_check($sformatf("rnd%0d", r), v, exp_offs.size(),
                            (v.dly >= 0) ? exp_offs.size() : 0,
                            (v.dly < 0) ? exp_offs.size() : 0);
        end

        // Asynchronous reset while armed.
        v = '{32'd500, 32'd500, 32'd1, 8'd1, 8'd1, 32'd0, 32'd0, 0, 0, 0, 0};
        configure(v, 32'h1234);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_arm(ok);
        tick();
        check("pre-reset busy in ARM", 64'({ok, busy}), 64'd3);
        #2 sc_reset = 1'b1;
        #1;
        check("async reset busy", 64'(busy), 64'd0);
        check("async reset card_rst_n", 64'(card_rst_n), 64'd1);
        check("async reset glitch", 64'(glitch), 64'd0);
        check("async reset io target", 64'(io_tgt), 64'd0);
        check("async reset clk target", 64'(clk_tgt), 64'd0);
        check("async reset done", 64'(done), 64'd0);
        tick();
        sc_reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
